// File: rtl/ring_seq_monitor_pkg.sv
// Shared definitions for the four-phase ring counter and its sequence monitor:
// phase code constants, the illegal-code set, FSM and transition encodings.
package ring_seq_monitor_pkg;

    localparam int PHASE_W = 3;

    // Legal ring codes in forward order (index 0..3)
    localparam logic [PHASE_W-1:0] PH_0 = 3'b001;
    localparam logic [PHASE_W-1:0] PH_1 = 3'b100;
    localparam logic [PHASE_W-1:0] PH_2 = 3'b110;
    localparam logic [PHASE_W-1:0] PH_3 = 3'b011;

    // Codes the ring counter can never legally produce
    localparam logic [PHASE_W-1:0] ILL_0 = 3'b000;
    localparam logic [PHASE_W-1:0] ILL_1 = 3'b010;
    localparam logic [PHASE_W-1:0] ILL_2 = 3'b101;
    localparam logic [PHASE_W-1:0] ILL_3 = 3'b111;

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TR_NONE = 2'd0,
        TR_FWD  = 2'd1,
        TR_HOLD = 2'd2,
        TR_BAD  = 2'd3
    } trans_t;

    function automatic logic illegal_code(input logic [PHASE_W-1:0] code);
        return (code == ILL_0) || (code == ILL_1) || (code == ILL_2) || (code == ILL_3);
    endfunction

endpackage

// File: rtl/ring_seq_monitor_decode.sv
// Combinational phase decoder: maps a 3-bit ring code to its 2-bit index and
// flags whether the code is one of the four legal codes.
module ring_phase_decode
    import ring_seq_monitor_pkg::*;
(
    input  logic [PHASE_W-1:0] code,
    output logic [1:0]         idx,
    output logic               valid
);

    // Table lookup; illegal codes report index 0 with valid low
    always_comb begin
        valid = ~illegal_code(code);
        case (code)
            PH_1:    idx = 2'd1;
            PH_2:    idx = 2'd2;
            PH_3:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/ring_seq_monitor.sv
// Ring counter sequence monitor. Samples the phase code, classifies each
// prev->cur step, locks after LOCK_CNT clean forward steps, counts completed
// revolutions while locked and holds a sticky fault on any bad step.
module ring_seq_monitor
    import ring_seq_monitor_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic               clr_err,
    output logic [1:0]         phase_idx,
    output logic               phase_valid,
    output logic               locked,
    output logic               seq_err,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               cycle_tick
);

    // run value whose next forward step completes lock acquisition
    localparam logic [3:0] RUN_LAST = 4'(LOCK_CNT - 1);

    logic [PHASE_W-1:0] cur;
    logic [PHASE_W-1:0] prev;
    logic               prev_ok;
    logic [3:0]         run;
    state_t             state;
    state_t             state_next;
    trans_t             trans;
    logic [1:0]         cur_idx;
    logic               cur_valid;
    logic               lock_step;
    logic               rev_step;
    logic               fault_clr;

    ring_phase_decode u_decode (
        .code  (cur),
        .idx   (cur_idx),
        .valid (cur_valid)
    );

    // phase_idx/phase_valid hold the decode of prev, so they serve as the
    // previous-sample index without a second decoder
    // Classify the prev->cur step once a legal sample has been seen
    always_comb begin
        trans = TR_NONE;
        if (prev_ok) begin
            if (cur_valid && phase_valid && (cur_idx == phase_idx + 2'd1)) begin
                trans = TR_FWD;
            end else if (cur_valid && (cur == prev)) begin
                trans = TR_HOLD;
            end else begin
                trans = TR_BAD;
            end
        end
    end

    assign lock_step = (state == UNLOCK) && (trans == TR_FWD) && (run == RUN_LAST);
    assign rev_step  = (state == LOCKED) && (trans == TR_FWD) &&
                       (phase_idx == 2'd3) && (cur_idx == 2'd0);
    assign fault_clr = (state == FAULT) && clr_err;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= UNLOCK;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; clr_err only matters in FAULT, where it beats any step
    always_comb begin
        state_next = state;
        case (state)
            UNLOCK:  if (lock_step) state_next = LOCKED;
            LOCKED:  if (trans == TR_BAD) state_next = FAULT;
            FAULT:   if (clr_err) state_next = UNLOCK;
            default: state_next = UNLOCK;
        endcase
    end

    // FSM outputs, decoded straight from the state register
    always_comb begin
        locked  = (state == LOCKED);
        seq_err = (state == FAULT);
    end

    // Sample pipeline: capture phase_in, keep the prior sample and its decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= '0;
            prev        <= '0;
            prev_ok     <= 1'b0;
            phase_idx   <= 2'd0;
            phase_valid <= 1'b0;
        end else begin
            cur         <= phase_in;
            prev        <= cur;
            prev_ok     <= fault_clr ? 1'b0 : (prev_ok | cur_valid);
            phase_valid <= cur_valid;
            if (cur_valid) begin
                phase_idx <= cur_idx;
            end
        end
    end

    // Lock acquisition run counter; only moves while unlocked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run <= 4'd0;
        end else if (fault_clr) begin
            run <= 4'd0;
        end else if (state == UNLOCK) begin
            if (trans == TR_FWD) begin
                run <= run + 4'd1;
            end else if (trans == TR_BAD) begin
                run <= 4'd0;
            end
        end
    end

    // Revolution counter and tick; the locking step itself is never counted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt  <= '0;
            cycle_tick <= 1'b0;
        end else begin
            cycle_tick <= rev_step;
            if (rev_step) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

endmodule
